// File: rtl/dp7_scan_driver.sv
// dp7_scan_driver
// Time-multiplexes four parallel 7-segment digit patterns onto one shared
// segment bus with per-digit active-low anodes. Each digit slot starts with a
// short all-dark blanking window (anti-ghosting). A brightness PWM window
// follows it, and the rest of the slot is dark. Digits flagged in blink_mask
// are suppressed during the "off" half of a free-running blink period. Inputs
// are sampled into shadow registers once per frame, so the display never
// tears. Any pattern that is not a decimal digit code or all-off raises a
// sticky error flag.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   seg_in1..4   digit 0..3 patterns, bit 6 = segment a, bit 0 = segment g
//   blink_mask   bit i = 1 makes digit i blink (used live, not shadowed)
//   dim          brightness 0 (dimmest) .. 15 (full), shadowed per frame
//   err_clr      clears err / err_digit (a simultaneous new error wins)
//   seg_out      shared segment bus, active-high, registered
//   an           digit enables, active-low, an[i] = digit i, registered
//   frame_start  one-cycle pulse in the cycle after the frame capture
//   err          sticky illegal-pattern flag
//   err_digit    lowest offending digit index at the latest error capture
//
// There is no handshake on this block: inputs are level signals sampled at
// frame capture, and outputs are free-running registered levels.

module dp7_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in1,
    input  logic [6:0] seg_in2,
    input  logic [6:0] seg_in3,
    input  logic [6:0] seg_in4,
    input  logic [3:0] blink_mask,
    input  logic [3:0] dim,
    input  logic       err_clr,
    output logic [6:0] seg_out,
    output logic [3:0] an,
    output logic       frame_start,
    output logic       err,
    output logic [1:0] err_digit
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // Wide enough for (SCAN_DIV-BLANK_CYC)*16 so the PWM product never truncates.
    localparam int PW = CW + 5;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [PW-1:0] SPAN       = PW'(SCAN_DIV - BLANK_CYC);
    localparam logic [PW-1:0] BLANK_W    = PW'(BLANK_CYC);

    logic [CW-1:0] slot_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [6:0]    shadow [4];
    logic [3:0]    dim_sh;

    logic [6:0]    seg_vec [4];
    logic          capture;
    logic          bad;
    logic [1:0]    bad_idx;
    logic [PW-1:0] prod;
    logic [PW-1:0] on_raw;
    logic [PW-1:0] on_len;
    logic [PW-1:0] slot_w;
    logic          in_on;
    logic          lit;

    // Decimal digit codes 0..9 plus the all-off pattern are the only legal values.
    function automatic logic is_legal(input logic [6:0] p);
        case (p)
            7'b0000000, 7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111,
            7'b1111011: is_legal = 1'b1;
            default:    is_legal = 1'b0;
        endcase
    endfunction

    assign seg_vec[0] = seg_in1;
    assign seg_vec[1] = seg_in2;
    assign seg_vec[2] = seg_in3;
    assign seg_vec[3] = seg_in4;

    always_comb begin
        capture = (idx == 2'd0) && (slot_cnt == '0);

        // Scan from the top down so the lowest offending index is the one kept.
        bad     = 1'b0;
        bad_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!is_legal(seg_vec[i])) begin
                bad     = 1'b1;
                bad_idx = 2'(i);
            end
        end

        prod   = SPAN * PW'({1'b0, dim_sh} + 5'd1);
        on_raw = prod >> 4;
        on_len = (on_raw == '0) ? PW'(1) : on_raw;

        slot_w = PW'(slot_cnt);
        in_on  = (slot_w >= BLANK_W) && (slot_w < BLANK_W + on_len);
        lit    = in_on && !(blink_phase && blink_mask[idx]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt    <= '0;
            idx         <= 2'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 7'd0;
            end
            dim_sh      <= 4'd15;
            seg_out     <= 7'd0;
            an          <= 4'b1111;
            frame_start <= 1'b0;
            err         <= 1'b0;
            err_digit   <= 2'd0;
        end else begin
            if (slot_cnt == SLOT_LAST) begin
                slot_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                slot_cnt <= slot_cnt + CW'(1);
            end

            // The blink timebase is independent of the scan and only reset by rst.
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            if (capture) begin
                for (int i = 0; i < 4; i++) begin
                    shadow[i] <= seg_vec[i];
                end
                dim_sh <= dim;
            end

            // Outputs reflect this cycle's scan state one cycle later.
            seg_out     <= lit ? shadow[idx] : 7'd0;
            an          <= lit ? ~(4'b0001 << idx) : 4'b1111;
            frame_start <= capture;

            // A newly detected error takes priority over a simultaneous clear.
            if (capture && bad) begin
                err       <= 1'b1;
                err_digit <= bad_idx;
            end else if (err_clr) begin
                err       <= 1'b0;
                err_digit <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_dp7_scan_driver.sv
// Testbench for dp7_scan_driver (SCAN_DIV=16, BLANK_CYC=2, BLINK_DIV=64).
// The stimulus process drives inputs once per cycle. A reference model keyed
// on the absolute cycle count since reset release predicts the next cycle's
// outputs and pushes them into exp_q. A monitor pops and compares on every
// falling edge.

module tb_dp7_scan_driver;

    localparam int S  = 16;
    localparam int BL = 2;
    localparam int BD = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in1, seg_in2, seg_in3, seg_in4;
    logic [3:0] blink_mask;
    logic [3:0] dim;
    logic       err_clr;
    logic [6:0] seg_out;
    logic [3:0] an;
    logic       frame_start;
    logic       err;
    logic [1:0] err_digit;

    always #5 clk = ~clk;

    dp7_scan_driver #(
        .SCAN_DIV  (S),
        .BLANK_CYC (BL),
        .BLINK_DIV (BD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in1     (seg_in1),
        .seg_in2     (seg_in2),
        .seg_in3     (seg_in3),
        .seg_in4     (seg_in4),
        .blink_mask  (blink_mask),
        .dim         (dim),
        .err_clr     (err_clr),
        .seg_out     (seg_out),
        .an          (an),
        .frame_start (frame_start),
        .err         (err),
        .err_digit   (err_digit)
    );

    // ---------------- scoreboard ----------------
    logic [14:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] codes [11] = '{7'b0000000, 7'b1111110, 7'b0110000, 7'b1101101,
                               7'b1111001, 7'b0110011, 7'b1011011, 7'b1011111,
                               7'b1110000, 7'b1111111, 7'b1111011};

    // ---------------- reference model state ----------------
    int         mdl_t;       // cycle index since reset release
    logic [6:0] m_sh [4];
    int         m_dim;
    logic       m_err;
    logic [1:0] m_ed;

    function automatic bit legal(input logic [6:0] p);
        for (int i = 0; i < 11; i++) begin
            if (p == codes[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: one output word per clock cycle.
    always @(negedge clk) begin
        logic [14:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("seg_out",     seg_out,             e[14:8]);
            chk("an",          7'(an),              7'(e[7:4]));
            chk("frame_start", 7'(frame_start),     7'(e[3]));
            chk("err",         7'(err),             7'(e[2]));
            chk("err_digit",   7'(err_digit),       7'(e[1:0]));
        end
    end

    // Predict the output of the next cycle from the inputs currently applied,
    // advance one clock, then hand the prediction to the monitor.
    task automatic cycle();
        logic [14:0] nxt;
        logic [6:0]  ins [4];
        logic [6:0]  sg;
        logic [3:0]  a;
        logic        fs;
        int          slot, id, onl, first_bad;
        bit          lit;
        ins = '{seg_in1, seg_in2, seg_in3, seg_in4};
        if (rst) begin
            nxt   = {7'd0, 4'hF, 1'b0, 1'b0, 2'd0};
            mdl_t = 0;
            for (int i = 0; i < 4; i++) m_sh[i] = 7'd0;
            m_dim = 15;
            m_err = 1'b0;
            m_ed  = 2'd0;
        end else begin
            slot = mdl_t % S;
            id   = (mdl_t / S) % 4;
            onl  = ((S - BL) * (m_dim + 1)) >> 4;
            if (onl < 1) onl = 1;
            lit  = (slot >= BL) && (slot < BL + onl) &&
                   !(((mdl_t / BD) % 2 == 1) && blink_mask[id]);
            sg   = 7'd0;
            a    = 4'hF;
            if (lit) begin
                sg    = m_sh[id];
                a[id] = 1'b0;
            end
            fs = (mdl_t % (4 * S) == 0);
            first_bad = -1;
            if (fs) begin
                for (int i = 3; i >= 0; i--) begin
                    if (!legal(ins[i])) first_bad = i;
                end
            end
            if (first_bad >= 0) begin
                m_err = 1'b1;
                m_ed  = 2'(first_bad);
            end else if (err_clr) begin
                m_err = 1'b0;
                m_ed  = 2'd0;
            end
            if (fs) begin
                for (int i = 0; i < 4; i++) m_sh[i] = ins[i];
                m_dim = int'(dim);
            end
            mdl_t++;
            nxt = {sg, a, fs, m_err, m_ed};
        end
        @(posedge clk);
        #1;
        exp_q.push_back(nxt);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        run(n);
        rst = 1'b0;
    endtask

    function automatic logic [6:0] rand_pat();
        if ($urandom_range(0, 7) == 0) return 7'($urandom);
        return codes[$urandom_range(0, 10)];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        seg_in1    = 7'd0;
        seg_in2    = 7'd0;
        seg_in3    = 7'd0;
        seg_in4    = 7'd0;
        blink_mask = 4'd0;
        dim        = 4'd15;
        err_clr    = 1'b0;
        mdl_t      = 0;
        m_dim      = 15;
        m_err      = 1'b0;
        m_ed       = 2'd0;
        for (int i = 0; i < 4; i++) m_sh[i] = 7'd0;
        @(posedge clk);
        #1;

        // Reset and plain scan at full brightness.
        seg_in1 = 7'b1111110;
        seg_in2 = 7'b0110000;
        seg_in3 = 7'b1101101;
        seg_in4 = 7'b1111001;
        do_reset(3);
        run(200);

        // PWM at mid and minimum brightness.
        dim = 4'd7;
        run(130);
        dim = 4'd0;
        run(130);
        dim = 4'd15;

        // Anti-tear: change digit 1 mid-frame.
        do_reset(2);
        seg_in2 = 7'b0110000;
        while (mdl_t != 5) cycle();
        seg_in2 = 7'b1101101;
        run(140);

        // Blink on digits 0 and 1.
        blink_mask = 4'b0011;
        do_reset(2);
        run(260);
        blink_mask = 4'b0000;

        // Illegal pattern on digit 2, displayed as-is.
        seg_in3 = 7'b0000001;
        while (mdl_t % 64 != 0) cycle();
        run(70);
        // Restore a legal pattern, then clear with no new error.
        seg_in3 = 7'b1011011;
        run(70);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        run(10);
        // Clear coinciding with a new error capture (two offending digits).
        seg_in1 = 7'b1000000;
        seg_in3 = 7'b0000001;
        while (mdl_t % 64 != 0) cycle();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        run(20);
        seg_in1 = 7'b1111110;
        seg_in3 = 7'b1101101;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        // Mid-frame reset at digit 2, slot count 9.
        while (mdl_t % 64 != 41) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        run(80);

        // Randomized operation.
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) seg_in1 = rand_pat();
            if ($urandom_range(0, 15) == 0) seg_in2 = rand_pat();
            if ($urandom_range(0, 15) == 0) seg_in3 = rand_pat();
            if ($urandom_range(0, 15) == 0) seg_in4 = rand_pat();
            if ($urandom_range(0, 49) == 0) dim = 4'($urandom);
            if ($urandom_range(0, 149) == 0) blink_mask = 4'($urandom);
            err_clr = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 399) == 0);
            cycle();
        end
        rst     = 1'b0;
        err_clr = 1'b0;
        run(2);

        #10;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dp7_scan_driver.md
Name: dp7_scan_driver

Overview:
- Consumes the four parallel 7-segment digit buses produced by the clock FSM (dp7_1..dp7_4, segment a at bit 6, g at bit 0, active-high).
- Drives a single time-multiplexed 4-digit display: one shared segment bus plus per-digit active-low anode enables.
- Adds anti-ghost blanking, per-digit blink for set modes, 16-level brightness PWM, and detection of illegal segment patterns.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; frame = 4*SCAN_DIV cycles. Must be > BLANK_CYC+1.
- BLANK_CYC, 500, cycles at the start of each slot during which all digits are dark.
- BLINK_DIV, 25000000, cycles per blink half-period.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- seg_in1  in  7  minutes-units pattern (digit 0)
- seg_in2  in  7  minutes-tens pattern (digit 1)
- seg_in3  in  7  hours-units pattern (digit 2)
- seg_in4  in  7  hours-tens pattern (digit 3)
- blink_mask  in  4  bit i=1: digit i blinks
- dim  in  4  brightness, 0 = dimmest, 15 = full
- err_clr  in  1  clears err and err_digit
- seg_out  out  7  shared segment bus, active-high, same bit order as inputs
- an  out  4  digit enables, active-low, an[i] = digit i
- frame_start  out  1  one-cycle pulse when a frame begins
- err  out  1  sticky illegal-pattern flag
- err_digit  out  2  index of the lowest-numbered offending digit at the latest error capture

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- Reset values: seg_out=0, an=4'b1111, frame_start=0, err=0, err_digit=0, slot_cnt=0, digit idx=0, blink counter=0, blink_phase=0, shadow registers=0, dim shadow=15.
- Counters:
  - slot_cnt runs 0..SCAN_DIV-1, then wraps to 0.
  - idx increments on each wrap, 3 wraps to 0.
  - The first cycle after reset release has slot_cnt=0 and idx=0.
- Frame capture: in the cycle with idx=0 and slot_cnt=0, all four seg_in values and dim are captured into shadow registers. The display uses only shadows, so mid-frame input changes never tear.
- Slot phases for digit idx:
  - BLANK: slot_cnt < BLANK_CYC.
  - ON: BLANK_CYC <= slot_cnt < BLANK_CYC+on_len.
  - OFF: remainder of the slot.
  - on_len = max(1, ((SCAN_DIV-BLANK_CYC)*(dim_shadow+1))>>4), computed at full precision with no truncation before the shift.
- Lit condition: phase==ON and NOT (blink_phase and blink_mask[idx]). blink_mask is used live, not shadowed.
- When lit: an = one-cold at idx and seg_out = shadow[idx]. Otherwise an=4'b1111 and seg_out=0. Exactly one or zero anodes are ever low.
- Output latency: seg_out, an and frame_start are registered and reflect the counter/phase state of the previous cycle (1-cycle lag).
- frame_start is high for the one cycle following the capture cycle.
- Blink:
  - The blink counter counts 0..BLINK_DIV-1; blink_phase toggles on wrap.
  - The blink counter is independent of the scan counters and free-runs; it is reset only by rst.
- Illegal pattern:
  - At capture, each shadow is checked against the ten digit codes (0..9, identical to the clock's encoding) plus all-off 7'b0000000.
  - Any mismatch sets err=1 and loads err_digit with the lowest offending index, on the cycle after capture.
  - Illegal patterns are still displayed as-is.
  - err_clr clears err and err_digit next cycle.
  - Simultaneous err_clr and a new error: set wins, and err_digit takes the new index.
- Reset mid-operation: the next cycle shows an=4'b1111 and seg_out=0. The scan restarts at digit 0 with a fresh capture, and the blink phase restarts at 0.
- Boundary values: dim=15 gives on_len = SCAN_DIV-BLANK_CYC, so the digit is lit to slot end. dim=0 gives on_len of at least 1 cycle.

Test Plan:
- Bench parameters for all cases: SCAN_DIV=16, BLANK_CYC=2, BLINK_DIV=64.
- Reset/scan, dim=15, blink_mask=0, seg_in1=7'b1111110: an=1111 during reset. After release, an=1110 with seg_out=1111110 for output cycles 3..16. Digits 1/2/3 follow at 16-cycle offsets. frame_start pulses at cycle 1 and every 64 cycles thereafter.
- PWM, dim=7: on_len=7, so each digit is lit for 7 consecutive cycles after 2 blank cycles, then dark for 7. dim=0: lit for exactly 1 cycle per slot.
- Anti-tear: change seg_in2 from 7'b0110000 to 7'b1101101 at slot_cnt=5 of digit 0. Digit 1 shows 0110000 for the rest of that frame and 1101101 from the next frame.
- Blink, blink_mask=4'b0011: during cycles 64..127 after release, an[0] and an[1] never go low while digits 2/3 scan normally. During cycles 128..191 all four are lit.
- Error: seg_in3=7'b0000001 → err=1 and err_digit=2 the cycle after capture, while seg_out still shows 0000001 on digit 2. Pulse err_clr with no error present → err=0. Assert err_clr in the same cycle as a new error capture → err stays 1.
- Mid-frame reset at idx=2, slot_cnt=9: the next cycle shows an=1111 and seg_out=0. After release, scanning restarts at digit 0 with a new capture and a frame_start pulse.
